// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes, response status codes
// and the request-driver state enum.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADOP   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_req_check.sv
// Combinational illegal-operand decoder: the divider only handles unsigned
// 7-bit positive operands with a non-zero divisor.
module alu_req_check
  import alu_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       illegal_o
);

  assign illegal_o = (op_i == OP_DIV) && ((b_i == 8'd0) || a_i[7] || b_i[7]);

endmodule

// File: rtl/alu_req_driver.sv
// Requester for the 8-bit sequential ALU: accepts op requests, pulses bgn,
// waits for endd and returns outbus with a status. ALU_REQ_TIMEOUT_EN adds a WAIT abort.
module alu_req_driver
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMR_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_operand1,
  output logic [7:0]  alu_operand2,
  output logic        alu_bgn,
  output logic        alu_rst,
  input  logic        alu_endd,
  input  logic [15:0] alu_outbus
);

  // A too-narrow timer shows up as this named block in the elaborated hierarchy.
  if ((64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_tmr_w_too_small
  end

  state_e      state_q;
  logic [1:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        bgn_q;
  logic        alu_rst_q;
  logic        rsp_valid_q;
  logic [15:0] result_q;
  logic [1:0]  status_q;
  logic        illegal;

`ifdef ALU_REQ_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q;
`endif

  alu_req_check u_check (
    .op_i      (req_op),
    .a_i       (req_a),
    .b_i       (req_b),
    .illegal_o (illegal)
  );

  // A stale endd from the previous operation must fall before a new launch.
  assign req_ready    = (state_q == S_IDLE) && !alu_endd;
  assign busy         = !rst && (state_q != S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_status   = status_q;
  assign alu_op       = op_q;
  assign alu_operand1 = a_q;
  assign alu_operand2 = b_q;
  assign alu_bgn      = bgn_q;
  assign alu_rst      = alu_rst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      op_q        <= 2'b00;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      bgn_q       <= 1'b0;
      alu_rst_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      result_q    <= 16'd0;
      status_q    <= ST_OK;
`ifdef ALU_REQ_TIMEOUT_EN
      tmr_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_INIT: begin
          alu_rst_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        S_IDLE: begin
          if (req_valid && !alu_endd) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            if (illegal) begin
              result_q    <= 16'd0;
              status_q    <= ST_BADOP;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              bgn_q   <= 1'b1;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          bgn_q   <= 1'b0;
          state_q <= S_WAIT;
`ifdef ALU_REQ_TIMEOUT_EN
          tmr_q   <= '0;
`endif
        end
        S_WAIT: begin
          // endd on the expiry cycle takes priority over the abort.
          if (alu_endd) begin
            result_q    <= alu_outbus;
            status_q    <= ST_OK;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
`ifdef ALU_REQ_TIMEOUT_EN
          else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            result_q    <= alu_outbus;
            status_q    <= ST_TIMEOUT;
            alu_rst_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
`endif
        end
        S_RESP: begin
          alu_rst_q <= 1'b0;
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed self-checking bench for alu_req_driver; the bench plays the ALU by
// driving endd/outbus with hand-computed results. Timeout test needs ALU_REQ_TIMEOUT_EN.
module tb_alu_req_driver;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [1:0]  alu_op;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic        alu_bgn;
  logic        alu_rst;
  logic        alu_endd;
  logic [15:0] alu_outbus;

  int tests;
  int fails;

  alu_req_driver #(
    .TIMEOUT_CYCLES (20),
    .TMR_W          (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_status   (rsp_status),
    .busy         (busy),
    .alu_op       (alu_op),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_bgn      (alu_bgn),
    .alu_rst      (alu_rst),
    .alu_endd     (alu_endd),
    .alu_outbus   (alu_outbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({rsp_valid, busy, alu_bgn, req_ready} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got valid/busy/bgn/ready=%b expected 0000",
               {rsp_valid, busy, alu_bgn, req_ready});
    end
    tests++;
    if (alu_rst !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_alu_rst: got %b expected 1", alu_rst);
    end
    tests++;
    if ({rsp_result, rsp_status, alu_op, alu_operand1, alu_operand2} !== 36'd0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h expected 0",
               {rsp_result, rsp_status, alu_op, alu_operand1, alu_operand2});
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({alu_rst, busy} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL init_cycle: got alu_rst/busy=%b expected 11", {alu_rst, busy});
    end
    step();
    tests++;
    if ({alu_rst, req_ready, busy} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL idle_after_init: got alu_rst/ready/busy=%b expected 010",
               {alu_rst, req_ready, busy});
    end
  endtask

  task automatic test_add();
    int bgnCount;
    drive_req(2'b00, 8'd100, 8'd27);
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL add_ready: got %b expected 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    bgnCount = 0;
    for (int i = 0; i < 5; i++) begin
      if (alu_bgn === 1'b1) bgnCount++;
      step();
    end
    alu_endd   = 1'b1;
    alu_outbus = 16'd127;
    #1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL add_early_valid: got %b expected 0", rsp_valid);
    end
    step();
    tests++;
    if ({rsp_valid, rsp_result, rsp_status} !== {1'b1, 16'd127, 2'b00}) begin
      fails++;
      $display("[TB] FAIL add_response: got valid=%b result=%0d status=%b expected 1 127 00",
               rsp_valid, rsp_result, rsp_status);
    end
    tests++;
    if (bgnCount !== 1) begin
      fails++;
      $display("[TB] FAIL add_bgn_pulses: got %0d expected 1", bgnCount);
    end
    alu_endd = 1'b0;
    finish_rsp();
    tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL add_back_idle: got valid/busy=%b expected 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_div();
    int bgnCount;
    int stableErr;
    drive_req(2'b11, 8'd144, 8'd5);
    step();
    req_valid = 1'b0;
    tests++;
    if ({rsp_valid, rsp_status, rsp_result, alu_bgn} !== {1'b1, 2'b01, 16'd0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL div_illegal: got valid=%b status=%b result=%h bgn=%b expected 1 01 0000 0",
               rsp_valid, rsp_status, rsp_result, alu_bgn);
    end
    finish_rsp();
    tests++;
    if (alu_bgn !== 1'b0) begin
      fails++;
      $display("[TB] FAIL div_illegal_bgn: got %b expected 0", alu_bgn);
    end

    drive_req(2'b11, 8'd100, 8'd7);
    step();
    req_valid = 1'b0;
    req_a     = 8'hFF;
    req_b     = 8'hFF;
    bgnCount  = 0;
    stableErr = 0;
    for (int i = 0; i < 4; i++) begin
      if (alu_bgn === 1'b1) bgnCount++;
      if (alu_op !== 2'b11 || alu_operand1 !== 8'd100 || alu_operand2 !== 8'd7) stableErr++;
      step();
    end
    alu_endd   = 1'b1;
    alu_outbus = 16'h020E;
    step();
    alu_endd = 1'b0;
    if (alu_op !== 2'b11 || alu_operand1 !== 8'd100 || alu_operand2 !== 8'd7) stableErr++;
    tests++;
    if ({rsp_valid, rsp_result, rsp_status} !== {1'b1, 16'h020E, 2'b00}) begin
      fails++;
      $display("[TB] FAIL div_response: got valid=%b result=%h status=%b expected 1 020e 00",
               rsp_valid, rsp_result, rsp_status);
    end
    tests++;
    if (bgnCount !== 1) begin
      fails++;
      $display("[TB] FAIL div_bgn_pulses: got %0d expected 1", bgnCount);
    end
    tests++;
    if (stableErr !== 0) begin
      fails++;
      $display("[TB] FAIL div_operands_stable: got %0d unstable cycles expected 0", stableErr);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int holdErr;
    int readyErr;
    drive_req(2'b10, 8'hFD, 8'h05);
    step();
    req_valid = 1'b0;
    step();
    step();
    alu_endd   = 1'b1;
    alu_outbus = 16'hFFF1;
    step();
    alu_endd = 1'b0;
    drive_req(2'b00, 8'd1, 8'd2);
    holdErr  = 0;
    readyErr = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 16'hFFF1 || rsp_status !== 2'b00) holdErr++;
      if (req_ready !== 1'b0) readyErr++;
      step();
    end
    tests++;
    if (holdErr !== 0) begin
      fails++;
      $display("[TB] FAIL mul_hold: got %0d unstable cycles expected 0", holdErr);
    end
    tests++;
    if (readyErr !== 0) begin
      fails++;
      $display("[TB] FAIL busy_no_accept: got %0d ready cycles expected 0", readyErr);
    end
    finish_rsp();
    tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL b2b_ready: got valid/ready=%b expected 01", {rsp_valid, req_ready});
    end
    step();
    req_valid = 1'b0;
    tests++;
    if ({alu_bgn, alu_op, alu_operand1, alu_operand2} !== {1'b1, 2'b00, 8'd1, 8'd2}) begin
      fails++;
      $display("[TB] FAIL b2b_launch: got bgn=%b op=%b a=%0d b=%0d expected 1 00 1 2",
               alu_bgn, alu_op, alu_operand1, alu_operand2);
    end
    step();
    alu_endd   = 1'b1;
    alu_outbus = 16'd3;
    step();
    alu_endd = 1'b0;
    tests++;
    if (rsp_result !== 16'd3) begin
      fails++;
      $display("[TB] FAIL b2b_result: got %0d expected 3", rsp_result);
    end
    finish_rsp();
  endtask

  task automatic test_endd_stuck();
    int readyErr;
    alu_endd = 1'b1;
    drive_req(2'b01, 8'd50, 8'd20);
    #1;
    readyErr = 0;
    for (int i = 0; i < 3; i++) begin
      if (req_ready !== 1'b0 || busy !== 1'b0) readyErr++;
      step();
    end
    tests++;
    if (readyErr !== 0) begin
      fails++;
      $display("[TB] FAIL stuck_endd_blocks: got %0d bad cycles expected 0", readyErr);
    end
    alu_endd = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stuck_endd_release: got %b expected 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    tests++;
    if ({alu_bgn, alu_op, alu_operand1} !== {1'b1, 2'b01, 8'd50}) begin
      fails++;
      $display("[TB] FAIL stuck_endd_launch: got bgn=%b op=%b a=%0d expected 1 01 50",
               alu_bgn, alu_op, alu_operand1);
    end
    step();
    alu_endd   = 1'b1;
    alu_outbus = 16'd30;
    step();
    alu_endd = 1'b0;
    tests++;
    if ({rsp_result, rsp_status} !== {16'd30, 2'b00}) begin
      fails++;
      $display("[TB] FAIL sub_result: got %0d/%b expected 30/00", rsp_result, rsp_status);
    end
    finish_rsp();
  endtask

  task automatic test_rst_mid_op();
    drive_req(2'b00, 8'd5, 8'd6);
    step();
    req_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, rsp_valid, alu_bgn, req_ready, alu_op, alu_operand1, alu_operand2} !== 22'd0) begin
      fails++;
      $display("[TB] FAIL rst_mid_outputs: got %h expected 0",
               {busy, rsp_valid, alu_bgn, req_ready, alu_op, alu_operand1, alu_operand2});
    end
    tests++;
    if (alu_rst !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_alu_rst: got %b expected 1", alu_rst);
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (alu_rst !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_init: got %b expected 1", alu_rst);
    end
    step();
    tests++;
    if ({alu_rst, req_ready, busy} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL rst_mid_idle: got alu_rst/ready/busy=%b expected 010",
               {alu_rst, req_ready, busy});
    end
  endtask

`ifdef ALU_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    alu_outbus = 16'hDEAD;
    drive_req(2'b00, 8'd9, 8'd9);
    step();
    req_valid = 1'b0;
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    tests++;
    if (cnt !== 21) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expected 21", cnt);
    end
    tests++;
    if ({rsp_status, rsp_result, alu_rst} !== {2'b10, 16'hDEAD, 1'b1}) begin
      fails++;
      $display("[TB] FAIL timeout_response: got status=%b result=%h alu_rst=%b expected 10 dead 1",
               rsp_status, rsp_result, alu_rst);
    end
    step();
    tests++;
    if (alu_rst !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_rst_pulse: got %b expected 0", alu_rst);
    end
    finish_rsp();
    tests++;
    if ({busy, req_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL timeout_idle: got busy/ready=%b expected 01", {busy, req_ready});
    end
  endtask
`endif

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 8'd0;
    req_b      = 8'd0;
    rsp_ready  = 1'b0;
    alu_endd   = 1'b0;
    alu_outbus = 16'd0;
    test_reset();
    test_add();
    test_div();
    test_back_to_back();
    test_endd_stuck();
    test_rst_mid_op();
`ifdef ALU_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_req_driver.md
Name: alu_req_driver

Overview:
- Host-side initiator for the 8-bit sequential ALU (data path plus control unit); it is the requester end of the op/operand/bgn/endd/outbus interface.
- Accepts operation requests on a valid/ready port, validates them, and drives op, operands and a one-cycle bgn.
- Waits for endd, captures outbus, and returns the result with a status code on a valid/ready response port.
- Sits between any sequencer or bus bridge and the ALU, and replaces hand-written bgn/rst stimulus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the operation is aborted. Only used with ALU_REQ_TIMEOUT_EN.
- TMR_W, 8: width of the timeout counter. Must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_op  in  2  00 add, 01 sub, 10 mul (Booth), 11 div
- req_a  in  8  first operand
- req_b  in  8  second operand
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_result  out  16  captured alu_outbus, unmodified
- rsp_status  out  2  00 ok, 01 illegal operand, 10 timeout
- busy  out  1  high in any state other than IDLE
- alu_op  out  2  op to the control unit
- alu_operand1  out  8  operand1 to the data path
- alu_operand2  out  8  operand2 to the data path
- alu_bgn  out  1  start pulse
- alu_rst  out  1  ALU reset; pulsed on reset exit and on abort
- alu_endd  in  1  ALU done
- alu_outbus  in  16  ALU result bus

Behaviour:
- Reset values: all outputs 0, except alu_rst=1 while rst is high. State=INIT.
- States: INIT, IDLE, LAUNCH, WAIT, RESP.
- INIT: alu_rst=1 for exactly one cycle after rst deasserts, then go to IDLE. This guarantees the ALU control unit is reset.
- IDLE: req_ready = ~alu_endd. This blocks launching while a stale endd is still high.
  - On handshake, register op, a and b into alu_op, alu_operand1 and alu_operand2.
  - Illegal operand: req_op==11 and (req_b==0 or req_a[7] or req_b[7]). The divider is unsigned 7-bit positive. Go straight to RESP with status 01, alu_bgn never asserted, rsp_result=0.
  - Otherwise go to LAUNCH.
- LAUNCH: alu_bgn=1 for exactly one cycle, then WAIT.
- Operands and op hold stable from the accept cycle until RESP is left. The ALU data path samples on the falling edge; holding for the whole operation keeps it safe.
- WAIT: on the first cycle alu_endd==1, capture alu_outbus into rsp_result and set status 00. Go to RESP.
- Latency: accept at cycle N → bgn at N+1 → endd at cycle E → rsp_valid at E+1.
- RESP: rsp_valid=1, and rsp_result/rsp_status are held stable until rsp_ready. On handshake, go to IDLE. Back-to-back operation is possible: the next accept occurs the cycle after the response handshake, if endd is low.
- A request arriving while busy is not accepted (req_ready=0). There is no queueing.
- alu_endd rising in any state other than WAIT is ignored.
- Async rst mid-operation: all state is cleared immediately and any pending response is lost. INIT reissues the ALU reset.
- Result format is defined by the ALU. The driver performs no sign extension or field splitting.

Optional Feature:
- Macro: ALU_REQ_TIMEOUT_EN.
- Defined:
  - A TMR_W counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with alu_endd still 0: rsp_result=alu_outbus (debug snapshot), status 10, alu_rst=1 for one cycle, go to RESP.
  - endd seen on the same cycle as expiry wins, giving status 00.
- Not defined: WAIT waits indefinitely, status 10 is never produced, and the counter is absent.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - status encodings ST_OK, ST_BADOP, ST_TIMEOUT;
  - the state enum.
- The ALU control unit and testbenches reuse the op encodings.
- One natural sub-module: alu_req_check, the combinational illegal-operand decoder. It is reusable by a future bus bridge.
- FSM, registers and timeout stay in the top module.

Test Plan:
- Add, 100 + 27, ALU model asserts endd at cycle 6 → exactly one alu_bgn pulse; rsp_result=127, status 00, rsp_valid one cycle after endd.
- Div, 144/5 (illegal, a[7]=1) → no bgn, status 01, rsp_result 0. Then div 100/7 → bgn issued, status 00, result equals the model's outbus, operands stable throughout.
- Mul, -3 × 5 (a=8'hFD) with rsp_ready held low 10 cycles after rsp_valid → rsp_result and status held stable. The next request is accepted only after the response handshake.
- req_valid high with alu_endd stuck high in IDLE → req_ready=0 until endd falls, then accepted.
- With ALU_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, model never raises endd → status 10 after 20 WAIT cycles, alu_rst one-cycle pulse, then IDLE.
- rst asserted during WAIT → outputs zero immediately, alu_rst high. After release: one-cycle alu_rst, then IDLE with req_ready=1.
